spi_slave_ctrl: RTL and testbench

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

---
 rtl/spi_slave_ctrl.sv | 110 +++++++++++
 tb/tb_spi_slave_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for a single-port RAM: decodes the select bit, assembles
// RX_W-bit command words for the RAM and serialises RAM read data back on miso.
module spi_slave_ctrl #(
    parameter int RX_W = 10,
    parameter int TX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ss_n,
    input  logic            mosi,
    output logic            miso,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    localparam int TXC_W = $clog2(TX_W + 1);
    localparam logic [3:0] RX_LAST = 4'(RX_W - 1);
    localparam logic [3:0] RX_FULL = 4'(RX_W);
    localparam logic [TXC_W-1:0] TX_LAST = TXC_W'(TX_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t           r_state;
    logic             r_rd_addr_seen;
    logic [3:0]       r_bit_cnt;
    // The final bit goes straight into rx_data, so only RX_W-1 bits are held here.
    logic [RX_W-2:0]  r_rx_sr;
    logic [TX_W-1:0]  r_tx_sr;
    logic [TXC_W-1:0] r_tx_cnt;
    logic             r_tx_busy;
    logic             r_tx_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_rd_addr_seen <= 1'b0;
            r_bit_cnt      <= '0;
            r_rx_sr        <= '0;
            r_tx_sr        <= '0;
            r_tx_cnt       <= '0;
            r_tx_busy      <= 1'b0;
            r_tx_done      <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            miso           <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (r_state != IDLE && ss_n) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_rx_sr   <= '0;
                r_tx_sr   <= '0;
                r_tx_cnt  <= '0;
                r_tx_busy <= 1'b0;
                r_tx_done <= 1'b0;
                miso      <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!ss_n) r_state <= CHK_CMD;
                    end
                    CHK_CMD: begin
                        if (!mosi)               r_state <= WRITE;
                        else if (r_rd_addr_seen) r_state <= READ_DATA;
                        else                     r_state <= READ_ADD;
                    end
                    default: begin
                        if (r_bit_cnt != RX_FULL) begin
                            r_rx_sr   <= {r_rx_sr[RX_W-3:0], mosi};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == RX_LAST) begin
                                rx_data  <= {r_rx_sr, mosi};
                                rx_valid <= 1'b1;
                                if (r_state == READ_ADD) r_rd_addr_seen <= 1'b1;
                            end
                        end else if (r_state == READ_DATA) begin
                            // Wait phase, then one shift-out per frame; later tx_valid is ignored.
                            if (r_tx_busy) begin
                                miso     <= r_tx_sr[TX_W-1];
                                r_tx_sr  <= {r_tx_sr[TX_W-2:0], 1'b0};
                                r_tx_cnt <= r_tx_cnt + TXC_W'(1);
                                if (r_tx_cnt == TX_LAST) begin
                                    r_tx_busy      <= 1'b0;
                                    r_tx_done      <= 1'b1;
                                    r_rd_addr_seen <= 1'b0;
                                end
                            end else begin
                                miso <= 1'b0;
                                if (!r_tx_done && tx_valid) begin
                                    r_tx_sr   <= tx_data;
                                    r_tx_cnt  <= '0;
                                    r_tx_busy <= 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Frame-level randomized bench for spi_slave_ctrl; expectations come from a
// position-in-frame model of the protocol rather than a copy of the FSM.
module tb_spi_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic       m_flag;
    logic [9:0] m_rx_data;

    spi_slave_ctrl #(.RX_W(10), .TX_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic m, input logic tv, input logic [7:0] td);
        @(negedge clk);
        ss_n     = s;
        mosi     = m;
        tx_valid = tv;
        tx_data  = td;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic exp_rxv, input logic exp_miso);
        check({tag, " rx_valid"}, 32'(rx_valid), 32'(exp_rxv));
        check({tag, " rx_data"},  32'(rx_data),  32'(m_rx_data));
        check({tag, " miso"},     32'(miso),     32'(exp_miso));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        #1;
        m_flag    = 1'b0;
        m_rx_data = '0;
        check_outs("reset_async", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outs("reset_held", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
            check_outs("idle", 1'b0, 1'b0);
        end
    endtask

    // Cycle 0: IDLE sees ss_n low; cycle 1: select bit; cycles 2..11: word MSB first.
    // Cycle len is the ss_n=1 edge. txm bit c drives tx_valid at cycle c.
    task automatic do_frame(input logic sel, input logic [9:0] word, input int len,
                            input logic [63:0] txm, input logic [7:0] txb, input int rst_at);
        logic rd;
        int   cap;
        logic s, m, tv, exp_rxv, exp_miso;
        rd  = sel && m_flag;
        cap = -1;
        for (int c = 0; c <= len; c++) begin
            if (c == rst_at) begin
                do_reset();
                return;
            end
            s  = (c == len);
            tv = txm[c];
            if (c == 1)                m = sel;
            else if (c >= 2 && c <= 11) m = word[11 - c];
            else                       m = 1'($urandom);
            step(s, m, tv, txb);
            exp_rxv = (c == 11) && !s;
            if (exp_rxv) m_rx_data = word;
            if (!s && rd && cap < 0 && c >= 12 && tv) cap = c;
            exp_miso = 1'b0;
            if (!s && cap >= 0 && c > cap && c <= cap + 8) exp_miso = txb[7 - (c - cap - 1)];
            if (!s && cap >= 0 && c == cap + 8) m_flag = 1'b0;
            check_outs($sformatf("frame sel%0d c%0d", sel, c), exp_rxv, exp_miso);
        end
        if (sel && !rd && len > 11) m_flag = 1'b1;
    endtask

    initial begin
        logic [63:0] txm;
        int          len;
        int          ra;
        rst       = 1'b1;
        ss_n      = 1'b1;
        mosi      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        m_flag    = 1'b0;
        m_rx_data = '0;
        #1;
        check_outs("por", 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        gap(2);

        // Write address, then write data with trailing bits.
        do_frame(1'b0, 10'h0A5, 13, '0, 8'h00, -1);
        gap(2);
        do_frame(1'b0, 10'h13C, 16, '0, 8'h00, -1);
        gap(1);

        // Read address then read data with tx_valid three cycles after rx_valid.
        do_frame(1'b1, 10'h207, 12, '0, 8'h00, -1);
        gap(1);
        do_frame(1'b1, 10'h35A, 30, 64'd1 << 14, 8'hC3, -1);
        gap(2);

        // Abort after six WRITE bits, then a normal frame.
        do_frame(1'b0, 10'h0FF, 8, '0, 8'h00, -1);
        gap(1);
        do_frame(1'b0, 10'h1E7, 12, '0, 8'h00, -1);
        gap(1);

        // Reset during shift-out after three bits; next select 1 is READ_ADD.
        do_frame(1'b1, 10'h211, 12, '0, 8'h00, -1);
        gap(1);
        do_frame(1'b1, 10'h3AB, 30, 64'd1 << 12, 8'hA5, 16);
        gap(1);
        do_frame(1'b1, 10'h2C0, 30, 64'd1 << 13, 8'hFF, -1);
        gap(1);
        do_frame(1'b1, 10'h3C0, 30, 64'd1 << 13, 8'h96, -1);
        gap(1);

        // tx_valid in IDLE and WRITE; abort coinciding with tx_valid in wait phase.
        gap(4);
        do_frame(1'b0, 10'h2AA, 20, '1, 8'hFF, -1);
        gap(1);
        do_frame(1'b1, 10'h201, 12, '0, 8'h00, -1);
        gap(1);
        do_frame(1'b1, 10'h3FE, 20, 64'd1 << 20, 8'hFF, -1);
        gap(2);
        do_frame(1'b1, 10'h3FE, 30, 64'd1 << 15, 8'h6D, -1);
        gap(1);

        for (int i = 0; i < 60; i++) begin
            len = int'($urandom_range(1, 34));
            txm = '0;
            for (int c = 0; c <= len; c++) txm[c] = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1;
            do_frame(1'($urandom), 10'($urandom), len, txm, 8'($urandom), ra);
            gap(int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
